// File: rtl/reg_writeback.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | reg_writeback: serialises ALU / load / mul-div results onto the register |
// | file write port with fixed priority plus starvation promotion.          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module reg_writeback #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst_n,

   input  logic        alu_valid,
   output logic        alu_ready,
   input  logic [5:0]  alu_rn,
   input  logic [63:0] alu_data,

   input  logic        mem_valid,
   output logic        mem_ready,
   input  logic [5:0]  mem_rn,
   input  logic [63:0] mem_data,

   input  logic        mul_valid,
   output logic        mul_ready,
   input  logic [5:0]  mul_rn,
   input  logic [63:0] mul_data,

   output logic        w_en,
   output logic [5:0]  w_rn,
   output logic [63:0] w_data
);

   localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

   logic [2:0]  alu_cnt, mem_cnt, mul_cnt;
   logic        alu_prom, mem_prom, mul_prom;
   logic        accept;
   logic [5:0]  sel_rn;
   logic [63:0] sel_data;

   // A source only counts as promoted while it is actually requesting.
   assign alu_prom = alu_valid && (alu_cnt == LIMIT);
   assign mem_prom = mem_valid && (mem_cnt == LIMIT);
   assign mul_prom = mul_valid && (mul_cnt == LIMIT);

   always_comb begin
      alu_ready = 1'b0;
      mem_ready = 1'b0;
      mul_ready = 1'b0;
      if (mem_prom)       mem_ready = 1'b1;
      else if (mul_prom)  mul_ready = 1'b1;
      else if (alu_prom)  alu_ready = 1'b1;
      else if (mem_valid) mem_ready = 1'b1;
      else if (mul_valid) mul_ready = 1'b1;
      else if (alu_valid) alu_ready = 1'b1;
   end

   assign accept = alu_ready | mem_ready | mul_ready;

   always_comb begin
      sel_rn   = alu_rn;
      sel_data = alu_data;
      if (mem_ready) begin
         sel_rn   = mem_rn;
         sel_data = mem_data;
      end else if (mul_ready) begin
         sel_rn   = mul_rn;
         sel_data = mul_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_cnt <= 3'd0;
         mem_cnt <= 3'd0;
         mul_cnt <= 3'd0;
      end else begin
         if (!alu_valid || alu_ready) alu_cnt <= 3'd0;
         else if (alu_cnt != LIMIT)   alu_cnt <= alu_cnt + 3'd1;

         if (!mem_valid || mem_ready) mem_cnt <= 3'd0;
         else if (mem_cnt != LIMIT)   mem_cnt <= mem_cnt + 3'd1;

         if (!mul_valid || mul_ready) mul_cnt <= 3'd0;
         else if (mul_cnt != LIMIT)   mul_cnt <= mul_cnt + 3'd1;
      end
   end

   // r0 results are consumed without a write so the bypass never forwards them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_en   <= 1'b0;
         w_rn   <= 6'd0;
         w_data <= 64'd0;
      end else begin
         w_en <= accept && (sel_rn != 6'd0);
         if (accept && (sel_rn != 6'd0)) begin
            w_rn   <= sel_rn;
            w_data <= sel_data;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_reg_writeback.sv
`default_nettype none
// Directed testbench for reg_writeback.
module tb_reg_writeback;

   localparam int LIMIT = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        alu_valid, alu_ready, mem_valid, mem_ready, mul_valid, mul_ready;
   logic [5:0]  alu_rn, mem_rn, mul_rn, w_rn;
   logic [63:0] alu_data, mem_data, mul_data, w_data;
   logic        w_en;

   int vectors = 0;
   int miscompares = 0;

   reg_writeback #(.STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .rst_n(rst_n),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rn(alu_rn), .alu_data(alu_data),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rn(mem_rn), .mem_data(mem_data),
      .mul_valid(mul_valid), .mul_ready(mul_ready), .mul_rn(mul_rn), .mul_data(mul_data),
      .w_en(w_en), .w_rn(w_rn), .w_data(w_data)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      repeat (2) @(posedge clk);
      #1;
      vectors++; if (w_en !== 1'b0) begin miscompares++; $display("FAIL reset_w_en: got %b expected 0", w_en); end
      vectors++; if (w_rn !== 6'd0) begin miscompares++; $display("FAIL reset_w_rn: got %0d expected 0", w_rn); end
      vectors++; if (w_data !== 64'd0) begin miscompares++; $display("FAIL reset_w_data: got %h expected 0", w_data); end
      vectors++; if ({mem_ready, mul_ready, alu_ready} !== 3'b000) begin miscompares++; $display("FAIL reset_ready: got %b expected 000", {mem_ready, mul_ready, alu_ready}); end
      rst_n = 1'b1;
      tick;
   endtask

   task automatic test_single_alu;
      alu_valid = 1'b1; alu_rn = 6'd5; alu_data = 64'h1234;
      #1;
      vectors++; if ({mem_ready, mul_ready, alu_ready} !== 3'b001) begin miscompares++; $display("FAIL single_ready: got %b expected 001", {mem_ready, mul_ready, alu_ready}); end
      tick;
      alu_valid = 1'b0;
      vectors++; if (w_en !== 1'b1) begin miscompares++; $display("FAIL single_w_en: got %b expected 1", w_en); end
      vectors++; if (w_rn !== 6'd5) begin miscompares++; $display("FAIL single_w_rn: got %0d expected 5", w_rn); end
      vectors++; if (w_data !== 64'h1234) begin miscompares++; $display("FAIL single_w_data: got %h expected 1234", w_data); end
      tick;
      vectors++; if (w_en !== 1'b0) begin miscompares++; $display("FAIL single_w_en_after: got %b expected 0", w_en); end
   endtask

   task automatic test_collision;
      mem_valid = 1'b1; mem_rn = 6'd1; mem_data = 64'h11;
      mul_valid = 1'b1; mul_rn = 6'd2; mul_data = 64'h22;
      alu_valid = 1'b1; alu_rn = 6'd3; alu_data = 64'h33;
      #1;
      vectors++; if ({mem_ready, mul_ready, alu_ready} !== 3'b100) begin miscompares++; $display("FAIL coll_c0_ready: got %b expected 100", {mem_ready, mul_ready, alu_ready}); end
      tick;
      mem_valid = 1'b0;
      #1;
      vectors++; if ({mem_ready, mul_ready, alu_ready} !== 3'b010) begin miscompares++; $display("FAIL coll_c1_ready: got %b expected 010", {mem_ready, mul_ready, alu_ready}); end
      vectors++; if ({w_en, w_rn} !== {1'b1, 6'd1}) begin miscompares++; $display("FAIL coll_c1_write: got en=%b rn=%0d expected en=1 rn=1", w_en, w_rn); end
      tick;
      mul_valid = 1'b0;
      #1;
      vectors++; if ({mem_ready, mul_ready, alu_ready} !== 3'b001) begin miscompares++; $display("FAIL coll_c2_ready: got %b expected 001", {mem_ready, mul_ready, alu_ready}); end
      vectors++; if ({w_en, w_rn} !== {1'b1, 6'd2}) begin miscompares++; $display("FAIL coll_c2_write: got en=%b rn=%0d expected en=1 rn=2", w_en, w_rn); end
      vectors++; if (w_data !== 64'h22) begin miscompares++; $display("FAIL coll_c2_data: got %h expected 22", w_data); end
      tick;
      alu_valid = 1'b0;
      vectors++; if ({w_en, w_rn} !== {1'b1, 6'd3}) begin miscompares++; $display("FAIL coll_c3_write: got en=%b rn=%0d expected en=1 rn=3", w_en, w_rn); end
      vectors++; if (w_data !== 64'h33) begin miscompares++; $display("FAIL coll_c3_data: got %h expected 33", w_data); end
      tick;
      vectors++; if (w_en !== 1'b0) begin miscompares++; $display("FAIL coll_c4_w_en: got %b expected 0", w_en); end
   endtask

   task automatic test_r0_discard;
      mul_valid = 1'b1; mul_rn = 6'd0; mul_data = 64'hFFFF;
      alu_valid = 1'b1; alu_rn = 6'd6; alu_data = 64'h66;
      #1;
      vectors++; if ({mem_ready, mul_ready, alu_ready} !== 3'b010) begin miscompares++; $display("FAIL r0_ready: got %b expected 010", {mem_ready, mul_ready, alu_ready}); end
      tick;
      mul_valid = 1'b0;
      #1;
      vectors++; if (w_en !== 1'b0) begin miscompares++; $display("FAIL r0_w_en: got %b expected 0", w_en); end
      vectors++; if ({mem_ready, mul_ready, alu_ready} !== 3'b001) begin miscompares++; $display("FAIL r0_next_ready: got %b expected 001", {mem_ready, mul_ready, alu_ready}); end
      tick;
      alu_valid = 1'b0;
      vectors++; if ({w_en, w_rn, w_data} !== {1'b1, 6'd6, 64'h66}) begin miscompares++; $display("FAIL r0_follow_write: got en=%b rn=%0d data=%h expected en=1 rn=6 data=66", w_en, w_rn, w_data); end
      tick;
   endtask

   task automatic test_starvation;
      alu_valid = 1'b1; alu_rn = 6'd7; alu_data = 64'hA7;
      mem_valid = 1'b1;
      for (int k = 0; k < LIMIT; k++) begin
         mem_rn = 6'(10 + k); mem_data = 64'(256 + k);
         #1;
         vectors++; if ({mem_ready, mul_ready, alu_ready} !== 3'b100) begin miscompares++; $display("FAIL starve_lose%0d_ready: got %b expected 100", k, {mem_ready, mul_ready, alu_ready}); end
         if (k > 0) begin
            vectors++; if ({w_en, w_rn} !== {1'b1, 6'(9 + k)}) begin miscompares++; $display("FAIL starve_lose%0d_write: got en=%b rn=%0d expected en=1 rn=%0d", k, w_en, w_rn, 9 + k); end
         end
         tick;
      end
      mem_rn = 6'd14; mem_data = 64'h104;
      #1;
      vectors++; if ({mem_ready, mul_ready, alu_ready} !== 3'b001) begin miscompares++; $display("FAIL starve_promote_ready: got %b expected 001", {mem_ready, mul_ready, alu_ready}); end
      vectors++; if ({w_en, w_rn} !== {1'b1, 6'd13}) begin miscompares++; $display("FAIL starve_c4_write: got en=%b rn=%0d expected en=1 rn=13", w_en, w_rn); end
      tick;
      alu_valid = 1'b0;
      #1;
      vectors++; if ({mem_ready, mul_ready, alu_ready} !== 3'b100) begin miscompares++; $display("FAIL starve_resume_ready: got %b expected 100", {mem_ready, mul_ready, alu_ready}); end
      vectors++; if ({w_en, w_rn, w_data} !== {1'b1, 6'd7, 64'hA7}) begin miscompares++; $display("FAIL starve_alu_write: got en=%b rn=%0d data=%h expected en=1 rn=7 data=a7", w_en, w_rn, w_data); end
      tick;
      mem_valid = 1'b0;
      vectors++; if ({w_en, w_rn, w_data} !== {1'b1, 6'd14, 64'h104}) begin miscompares++; $display("FAIL starve_mem_write: got en=%b rn=%0d data=%h expected en=1 rn=14 data=104", w_en, w_rn, w_data); end
      tick;
      vectors++; if (w_en !== 1'b0) begin miscompares++; $display("FAIL starve_idle_w_en: got %b expected 0", w_en); end
   endtask

   task automatic test_back_pressure;
      mul_valid = 1'b1; mul_rn = 6'd8; mul_data = 64'h88;
      mem_valid = 1'b1;
      for (int k = 0; k < LIMIT; k++) begin
         mem_rn = 6'(20 + k); mem_data = 64'(512 + k);
         #1;
         vectors++; if ({mem_ready, mul_ready, alu_ready} !== 3'b100) begin miscompares++; $display("FAIL bp_mem%0d_ready: got %b expected 100", k, {mem_ready, mul_ready, alu_ready}); end
         tick;
      end
      mem_rn = 6'd4; mem_data = 64'hDEAD;
      #1;
      vectors++; if ({mem_ready, mul_ready, alu_ready} !== 3'b010) begin miscompares++; $display("FAIL bp_hold_ready: got %b expected 010", {mem_ready, mul_ready, alu_ready}); end
      tick;
      mul_valid = 1'b0;
      #1;
      vectors++; if ({mem_ready, mul_ready, alu_ready} !== 3'b100) begin miscompares++; $display("FAIL bp_release_ready: got %b expected 100", {mem_ready, mul_ready, alu_ready}); end
      vectors++; if ({w_en, w_rn, w_data} !== {1'b1, 6'd8, 64'h88}) begin miscompares++; $display("FAIL bp_mul_write: got en=%b rn=%0d data=%h expected en=1 rn=8 data=88", w_en, w_rn, w_data); end
      tick;
      mem_valid = 1'b0;
      vectors++; if ({w_en, w_rn, w_data} !== {1'b1, 6'd4, 64'hDEAD}) begin miscompares++; $display("FAIL bp_mem_write: got en=%b rn=%0d data=%h expected en=1 rn=4 data=dead", w_en, w_rn, w_data); end
      tick;
   endtask

   task automatic test_reset_midflight;
      alu_valid = 1'b1; alu_rn = 6'd9; alu_data = 64'h99;
      #1;
      vectors++; if ({mem_ready, mul_ready, alu_ready} !== 3'b001) begin miscompares++; $display("FAIL mid_ready: got %b expected 001", {mem_ready, mul_ready, alu_ready}); end
      tick;
      alu_valid = 1'b0;
      #1;
      rst_n = 1'b0;
      #1;
      vectors++; if (w_en !== 1'b0) begin miscompares++; $display("FAIL mid_async_w_en: got %b expected 0", w_en); end
      vectors++; if (w_rn !== 6'd0) begin miscompares++; $display("FAIL mid_async_w_rn: got %0d expected 0", w_rn); end
      vectors++; if (w_data !== 64'd0) begin miscompares++; $display("FAIL mid_async_w_data: got %h expected 0", w_data); end
      tick;
      rst_n = 1'b1;
      tick;
      vectors++; if ({w_en, w_rn} !== {1'b0, 6'd0}) begin miscompares++; $display("FAIL mid_after_reset: got en=%b rn=%0d expected en=0 rn=0", w_en, w_rn); end
      vectors++; if ({mem_ready, mul_ready, alu_ready} !== 3'b000) begin miscompares++; $display("FAIL mid_idle_ready: got %b expected 000", {mem_ready, mul_ready, alu_ready}); end
   endtask

   initial begin
      rst_n = 1'b0;
      alu_valid = 1'b0; alu_rn = 6'd0; alu_data = 64'd0;
      mem_valid = 1'b0; mem_rn = 6'd0; mem_data = 64'd0;
      mul_valid = 1'b0; mul_rn = 6'd0; mul_data = 64'd0;
      test_reset;
      test_single_alu;
      test_collision;
      test_r0_discard;
      test_starvation;
      test_back_pressure;
      test_reset_midflight;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
